// File: rtl/hw_config_probe.sv
// hw_config_probe: fetches the RAM-size, device-mask and CPU-info config
// words over a strobe/busy read port and holds them as result registers.
`timescale 1ns/1ps
module hw_config_probe #(
    parameter logic [31:0] MEMORY_ADDR  = 32'h0040_0804,
    parameter logic [31:0] DEVICES_ADDR = 32'h0040_1004,
    parameter logic [31:0] CPUINFO_ADDR = 32'h0040_2004,
    parameter int unsigned TIMEOUT      = 16,
    parameter bit          AUTO_START   = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    output logic [31:0] mem_addr,
    output logic        mem_rstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rbusy,
    output logic [31:0] ram_size,
    output logic [31:0] devices,
    output logic [15:0] freq_mhz,
    output logic [15:0] counter_width,
    output logic        busy,
    output logic        valid,
    output logic        error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [1:0] IDX_LAST = 2'd2;

    state_t      r_state;
    state_t      w_next;
    logic        r_armed;
    logic [1:0]  r_idx;
    logic [7:0]  r_tmo;
    logic        r_valid;
    logic        r_error;
    logic [31:0] r_ram;
    logic [31:0] r_dev;
    logic [31:0] r_cpu;

    logic        w_launch;
    logic        w_got;
    logic        w_last;
    logic        w_tmo;
    logic [31:0] w_sel_addr;

    // The auto launch is a one-shot armed by reset and consumed on the
    // first clock; a start in that cycle merges into the same launch.
    assign w_launch = (r_state == S_IDLE) && (start || r_armed);
    assign w_got    = (r_state == S_WAIT) && !mem_rbusy;
    assign w_last   = (r_idx == IDX_LAST);
    assign w_tmo    = (r_state == S_WAIT) && mem_rbusy
                      && (r_tmo == TMO_LAST);

    always_comb begin
        w_sel_addr = 32'h0;
        unique case (r_idx)
            2'd0:    w_sel_addr = MEMORY_ADDR;
            2'd1:    w_sel_addr = DEVICES_ADDR;
            2'd2:    w_sel_addr = CPUINFO_ADDR;
            default: w_sel_addr = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_got) begin
                    w_next = w_last ? S_DONE : S_REQ;
                end else if (w_tmo) begin
                    w_next = S_IDLE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_rstrb = 1'b0;
        mem_addr  = 32'h0;
        busy      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_REQ: begin
                mem_rstrb = 1'b1;
                mem_addr  = w_sel_addr;
                busy      = 1'b1;
            end
            S_WAIT: begin
                busy = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_armed <= AUTO_START;
        end else begin
            r_armed <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_idx <= 2'd0;
        end else if (w_launch) begin
            r_idx <= 2'd0;
        end else if (w_got && !w_last) begin
            r_idx <= r_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tmo <= 8'd0;
        end else if (r_state == S_REQ) begin
            r_tmo <= 8'd0;
        end else if ((r_state == S_WAIT) && mem_rbusy
                     && (r_tmo != 8'hFF)) begin
            r_tmo <= r_tmo + 8'd1;
        end
    end

    // valid rises as the last word lands, so it is already set in DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_error <= 1'b0;
        end else if (w_launch) begin
            r_valid <= 1'b0;
            r_error <= 1'b0;
        end else begin
            if (w_got && w_last) begin
                r_valid <= 1'b1;
            end
            if (w_tmo) begin
                r_error <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ram <= 32'h0;
            r_dev <= 32'h0;
            r_cpu <= 32'h0;
        end else if (w_got) begin
            unique case (r_idx)
                2'd0:    r_ram <= mem_rdata;
                2'd1:    r_dev <= mem_rdata;
                2'd2:    r_cpu <= mem_rdata;
                default: r_cpu <= r_cpu;
            endcase
        end
    end

    assign ram_size      = r_ram;
    assign devices       = r_dev;
    assign freq_mhz      = r_cpu[31:16];
    assign counter_width = r_cpu[15:0];
    assign valid         = r_valid;
    assign error         = r_error;

endmodule

// File: tb/tb_hw_config_probe.sv
// Bench for hw_config_probe: auto-start instance with a stalling responder
// plus a manual-start instance used for the mid-scan reset case.
`timescale 1ns/1ps
module tb_hw_config_probe;

    localparam logic [31:0] MA = 32'h0040_0804;
    localparam logic [31:0] DA = 32'h0040_1004;
    localparam logic [31:0] CA = 32'h0040_2004;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- instance A: auto start ----------------
    logic        a_rstn = 1'b1;
    logic        a_start = 1'b0;
    logic [31:0] a_addr, a_rdata, a_ram, a_dev;
    logic        a_rstrb, a_rbusy, a_busy, a_valid, a_err;
    logic [15:0] a_freq, a_cw;

    logic [31:0] d_mem, d_dev, d_cpu;
    logic [31:0] stall_addr = 32'h0;
    int          stall_n = 0;
    logic [31:0] a_last = 32'h0;
    int          a_left = 0;
    logic [31:0] exp_q[$];

    hw_config_probe #(.TIMEOUT(16), .AUTO_START(1'b1)) dut_a (
        .clk(clk), .resetn(a_rstn), .start(a_start),
        .mem_addr(a_addr), .mem_rstrb(a_rstrb),
        .mem_rdata(a_rdata), .mem_rbusy(a_rbusy),
        .ram_size(a_ram), .devices(a_dev),
        .freq_mhz(a_freq), .counter_width(a_cw),
        .busy(a_busy), .valid(a_valid), .error(a_err)
    );

    always @(posedge clk) begin
        if (a_rstrb) begin
            a_last <= a_addr;
            a_left <= (a_addr == stall_addr) ? stall_n : 0;
        end else if (a_left > 0) begin
            a_left <= a_left - 1;
        end
    end
    assign a_rbusy = (a_left != 0);
    assign a_rdata = (a_last == MA) ? d_mem :
                     (a_last == DA) ? d_dev :
                     (a_last == CA) ? d_cpu : 32'hDEAD_BEEF;

    always @(negedge clk) begin
        if (a_rstrb) begin
            if (exp_q.size() == 0) chk("extra_strobe", a_addr, 32'h0);
            else chk("strobe_addr", a_addr, exp_q.pop_front());
        end else begin
            chk("addr_idle", a_addr, 32'h0);
        end
    end

    // ---------------- instance B: manual start ----------------
    logic        b_rstn = 1'b1;
    logic        b_start = 1'b0;
    logic [31:0] b_addr, b_rdata, b_ram, b_dev;
    logic        b_rstrb, b_busy, b_valid, b_err;
    logic [15:0] b_freq, b_cw;
    logic [31:0] b_last = 32'h0;
    int          b_strobes = 0;

    hw_config_probe #(.AUTO_START(1'b0)) dut_b (
        .clk(clk), .resetn(b_rstn), .start(b_start),
        .mem_addr(b_addr), .mem_rstrb(b_rstrb),
        .mem_rdata(b_rdata), .mem_rbusy(1'b0),
        .ram_size(b_ram), .devices(b_dev),
        .freq_mhz(b_freq), .counter_width(b_cw),
        .busy(b_busy), .valid(b_valid), .error(b_err)
    );

    always @(posedge clk) begin
        if (b_rstrb) begin
            b_last <= b_addr;
            b_strobes++;
        end
    end
    assign b_rdata = (b_last == MA) ? 32'h0000_4000 :
                     (b_last == DA) ? 32'h0000_0003 :
                     (b_last == CA) ? 32'h0019_0010 : 32'h0;

    // ---------------- helpers ----------------
    task automatic push3();
        exp_q.push_back(MA);
        exp_q.push_back(DA);
        exp_q.push_back(CA);
    endtask

    task automatic pulse_a(output int t0);
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        t0 = cyc;
    endtask

    // Counts edges from the launch edge (edge 1) until the condition holds.
    task automatic wait_a(input bit on_valid, input int t0,
                          input int exp_n, input string tag);
        int n = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (on_valid ? a_valid : !a_busy) begin
                n = cyc - t0 + 1;
                break;
            end
        end
        chk(tag, n, exp_n);
    endtask

    task automatic check_a(input logic [31:0] ram, input logic [31:0] dev,
                           input logic [15:0] fq, input logic [15:0] cw);
        chk("ram_size", a_ram, ram);
        chk("devices", a_dev, dev);
        chk("freq_mhz", 32'(a_freq), 32'(fq));
        chk("counter_width", 32'(a_cw), 32'(cw));
    endtask

    task automatic drain_a();
        repeat (4) @(negedge clk);
        chk("busy_idle", a_busy, 1'b0);
        chk("missing_strobe", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1);
    end

    initial begin
        int t0;
        d_mem = 32'h0001_8000;
        d_dev = 32'h0000_01FF;
        d_cpu = 32'h0032_0020;
        #2;
        a_rstn = 1'b0;
        b_rstn = 1'b0;
        #1;
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_valid", a_valid, 1'b0);
        chk("rst_error", a_err, 1'b0);
        chk("rst_rstrb", a_rstrb, 1'b0);
        check_a(32'h0, 32'h0, 16'h0, 16'h0);
        repeat (3) @(negedge clk);

        // auto-start scan, zero wait
        push3();
        a_rstn = 1'b1;
        t0 = cyc + 1;
        wait_a(1'b1, t0, 7, "auto_valid_cycles");
        check_a(32'h0001_8000, 32'h0000_01FF, 16'd50, 16'd32);
        chk("auto_error", a_err, 1'b0);
        drain_a();
        chk("valid_held", a_valid, 1'b1);

        // 3-cycle stall on devices, start pulsed mid-scan, new data
        d_mem = 32'h0010_0000;
        d_dev = 32'h0000_00F3;
        d_cpu = 32'h0064_0040;
        stall_addr = DA;
        stall_n = 3;
        push3();
        pulse_a(t0);
        chk("valid_drop", a_valid, 1'b0);
        chk("busy_scan", a_busy, 1'b1);
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        wait_a(1'b1, t0, 10, "stall_valid_cycles");
        check_a(32'h0010_0000, 32'h0000_00F3, 16'd100, 16'd64);
        drain_a();

        // CPU-info read stuck busy: timeout after 16 busy cycles
        d_mem = 32'h0002_0000;
        d_dev = 32'h0000_0007;
        d_cpu = 32'h1234_5678;
        stall_addr = CA;
        stall_n = 1000;
        push3();
        pulse_a(t0);
        wait_a(1'b0, t0, 22, "timeout_cycles");
        chk("tmo_error", a_err, 1'b1);
        chk("tmo_valid", a_valid, 1'b0);
        check_a(32'h0002_0000, 32'h0000_0007, 16'd100, 16'd64);
        drain_a();

        // back-to-back clean scan clears error
        stall_addr = 32'h0;
        d_mem = 32'h0004_0000;
        d_dev = 32'h8000_0001;
        d_cpu = 32'h00C8_0018;
        push3();
        pulse_a(t0);
        chk("err_cleared", a_err, 1'b0);
        wait_a(1'b1, t0, 7, "rescan_valid_cycles");
        check_a(32'h0004_0000, 32'h8000_0001, 16'd200, 16'd24);
        drain_a();

        // instance B: no auto launch, mid-scan async reset
        b_rstn = 1'b1;
        repeat (10) @(negedge clk);
        chk("b_no_auto", b_strobes, 0);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("b_two_strobes", b_strobes, 2);
        chk("b_ram_mid", b_ram, 32'h0000_4000);
        b_rstn = 1'b0;
        #1;
        chk("b_rst_busy", b_busy, 1'b0);
        chk("b_rst_rstrb", b_rstrb, 1'b0);
        chk("b_rst_addr", b_addr, 32'h0);
        chk("b_rst_ram", b_ram, 32'h0);
        chk("b_rst_dev", b_dev, 32'h0);
        chk("b_rst_flags", {b_valid, b_err, b_freq, b_cw}, 32'h0);
        repeat (2) @(negedge clk);
        b_rstn = 1'b1;
        repeat (10) @(negedge clk);
        chk("b_no_restart", b_strobes, 2);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int i = 0; i < 20 && !b_valid; i++) @(negedge clk);
        chk("b_valid", b_valid, 1'b1);
        chk("b_strobes", b_strobes, 5);
        chk("b_ram", b_ram, 32'h0000_4000);
        chk("b_dev", b_dev, 32'h0000_0003);
        chk("b_freq", 32'(b_freq), 32'd25);
        chk("b_cw", 32'(b_cw), 32'd16);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
